// File: rtl/pwm_reg_bank_if.sv
// rtl/pwm_reg_bank_if.sv - register-file input and PWM output bundle for pwm_reg_bank
interface pwm_reg_bank_if #(
    parameter int REGCOUNT = 20,
    parameter int NUM_CH   = 8
);
    logic [8*REGCOUNT-1:0] registers_packed;
    logic [NUM_CH-1:0]     pwm_out;
    logic [NUM_CH-1:0]     period_wrap;
    logic                  tick;

    modport master (
        output registers_packed,
        input  pwm_out,
        input  period_wrap,
        input  tick
    );

    modport slave (
        input  registers_packed,
        output pwm_out,
        output period_wrap,
        output tick
    );
endinterface

// File: rtl/pwm_reg_bank.sv
// rtl/pwm_reg_bank.sv - multi-channel PWM driven by an I2C register file, shared prescaler
module pwm_reg_bank #(
    parameter int REGCOUNT = 20,
    parameter int NUM_CH   = 8
) (
    input  logic          clock,
    input  logic          reset,
    pwm_reg_bank_if.slave bus
);

    typedef enum logic {
        DISABLED = 1'b0,
        RUNNING  = 1'b1
    } ch_state_t;

    logic [NUM_CH-1:0] en_live;
    logic [7:0]        prescale;
    logic [7:0]        per_live  [NUM_CH];
    logic [7:0]        duty_live [NUM_CH];
    logic              unused_regs;

    assign en_live     = bus.registers_packed[NUM_CH-1:0];
    assign prescale    = bus.registers_packed[15:8];
    assign unused_regs = ^bus.registers_packed;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fields
        assign per_live[g]  = bus.registers_packed[8*(2+2*g) +: 8];
        assign duty_live[g] = bus.registers_packed[8*(3+2*g) +: 8];
    end

    logic [7:0]        pre_cnt, pre_cnt_nx;
    logic              tick_now;
    logic              tick_q;

    ch_state_t         state_q    [NUM_CH];
    ch_state_t         state_nx   [NUM_CH];
    logic [7:0]        cnt_q      [NUM_CH];
    logic [7:0]        cnt_nx     [NUM_CH];
    logic [7:0]        per_sh_q   [NUM_CH];
    logic [7:0]        per_sh_nx  [NUM_CH];
    logic [7:0]        duty_sh_q  [NUM_CH];
    logic [7:0]        duty_sh_nx [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_nx;
    logic [NUM_CH-1:0] wrap_q, wrap_nx;
    logic [7:0]        cnt_cur;

    // ">=" rather than "==" so lowering P mid-count never waits out a full 8-bit wrap.
    always_comb begin
        tick_now   = (pre_cnt >= prescale);
        pre_cnt_nx = tick_now ? 8'd0 : pre_cnt + 8'd1;
    end

    always_comb begin
        cnt_cur = 8'd0;
        pwm_nx  = '0;
        wrap_nx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_nx[i]   = state_q[i];
            cnt_nx[i]     = cnt_q[i];
            per_sh_nx[i]  = per_sh_q[i];
            duty_sh_nx[i] = duty_sh_q[i];

            if (!en_live[i]) begin
                // Shadows track the live registers so enabling starts on fresh values.
                state_nx[i]   = DISABLED;
                cnt_nx[i]     = 8'd0;
                per_sh_nx[i]  = per_live[i];
                duty_sh_nx[i] = duty_live[i];
            end else begin
                state_nx[i] = RUNNING;
                cnt_cur     = (state_q[i] == DISABLED) ? 8'd0 : cnt_q[i];
                pwm_nx[i]   = (cnt_cur < duty_sh_q[i]);
                if (tick_now) begin
                    if (cnt_cur == per_sh_q[i]) begin
                        cnt_nx[i]     = 8'd0;
                        per_sh_nx[i]  = per_live[i];
                        duty_sh_nx[i] = duty_live[i];
                        wrap_nx[i]    = 1'b1;
                    end else begin
                        cnt_nx[i] = cnt_cur + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt <= 8'd0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            wrap_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= DISABLED;
                cnt_q[i]     <= 8'd0;
                per_sh_q[i]  <= 8'd0;
                duty_sh_q[i] <= 8'd0;
            end
        end else begin
            pre_cnt <= pre_cnt_nx;
            tick_q  <= tick_now;
            pwm_q   <= pwm_nx;
            wrap_q  <= wrap_nx;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= state_nx[i];
                cnt_q[i]     <= cnt_nx[i];
                per_sh_q[i]  <= per_sh_nx[i];
                duty_sh_q[i] <= duty_sh_nx[i];
            end
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_wrap = wrap_q;
    assign bus.tick        = tick_q;

endmodule

// File: tb/tb_pwm_reg_bank.sv
// tb/tb_pwm_reg_bank.sv - directed and randomized checks of pwm_reg_bank against a reference model
module tb_pwm_reg_bank;

    localparam int REGCOUNT = 20;
    localparam int NUM_CH   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_reg_bank_if #(.REGCOUNT(REGCOUNT), .NUM_CH(NUM_CH)) bus ();

    pwm_reg_bank #(.REGCOUNT(REGCOUNT), .NUM_CH(NUM_CH)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [7:0] regs [REGCOUNT];

    always_comb begin
        for (int k = 0; k < REGCOUNT; k++) bus.registers_packed[8*k +: 8] = regs[k];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    int m_pre;
    bit m_tick;
    int m_cnt  [NUM_CH];
    int m_per  [NUM_CH];
    int m_duty [NUM_CH];
    bit m_pwm  [NUM_CH];
    bit m_wrap [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: reference advances from the pre-edge register file, then the DUT is compared.
    task automatic step();
        int nx_pre;
        bit nx_tick;
        int nx_cnt [NUM_CH];
        int nx_per [NUM_CH];
        int nx_duty [NUM_CH];
        bit nx_pwm [NUM_CH];
        bit nx_wrap [NUM_CH];
        bit tn;
        logic [NUM_CH-1:0] e_pwm, e_wrap;
        tn = (m_pre >= int'(regs[1]));
        nx_pre  = tn ? 0 : m_pre + 1;
        nx_tick = tn;
        for (int i = 0; i < NUM_CH; i++) begin
            nx_cnt[i] = m_cnt[i]; nx_per[i] = m_per[i]; nx_duty[i] = m_duty[i];
            nx_pwm[i] = 1'b0; nx_wrap[i] = 1'b0;
            if (!regs[0][i]) begin
                nx_cnt[i]  = 0;
                nx_per[i]  = int'(regs[2+2*i]);
                nx_duty[i] = int'(regs[3+2*i]);
            end else begin
                nx_pwm[i] = (m_cnt[i] < m_duty[i]);
                if (tn) begin
                    if (m_cnt[i] == m_per[i]) begin
                        nx_cnt[i]  = 0;
                        nx_per[i]  = int'(regs[2+2*i]);
                        nx_duty[i] = int'(regs[3+2*i]);
                        nx_wrap[i] = 1'b1;
                    end else begin
                        nx_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
        if (rst) begin
            nx_pre = 0; nx_tick = 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                nx_cnt[i] = 0; nx_per[i] = 0; nx_duty[i] = 0; nx_pwm[i] = 1'b0; nx_wrap[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_pre = nx_pre; m_tick = nx_tick;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = nx_cnt[i]; m_per[i] = nx_per[i]; m_duty[i] = nx_duty[i];
            m_pwm[i] = nx_pwm[i]; m_wrap[i] = nx_wrap[i];
            e_pwm[i] = nx_pwm[i]; e_wrap[i] = nx_wrap[i];
        end
        check("model_pwm_out", 32'(bus.pwm_out), 32'(e_pwm));
        check("model_period_wrap", 32'(bus.period_wrap), 32'(e_wrap));
        check("model_tick", 32'(bus.tick), 32'(m_tick));
    endtask

    task automatic wait_wrap(input int ch);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 1200 && !found; n++) begin
            step();
            found = bus.period_wrap[ch];
        end
        check("wait_wrap", 32'(found), 32'd1);
    endtask

    // Checks nper whole periods from a wrap using the closed-form period/high-time rules.
    task automatic check_period(input int ch, input int per, input int d, input int p, input int nper);
        int len, hi, jj;
        len = (per + 1) * (p + 1);
        hi  = ((d < per + 1) ? d : per + 1) * (p + 1);
        wait_wrap(ch);
        for (int j = 1; j <= len * nper; j++) begin
            step();
            jj = (j - 1) % len + 1;
            check("pattern_pwm", 32'(bus.pwm_out[ch]), 32'(jj <= hi));
            check("pattern_wrap", 32'(bus.period_wrap[ch]), 32'(jj == len));
            check("pattern_tick", 32'(bus.tick), 32'((jj % (p + 1)) == 0));
        end
    endtask

    initial begin
        int  n;
        bit  found;
        m_pre = 0; m_tick = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_pwm[i] = 1'b0; m_wrap[i] = 1'b0;
        end
        for (int k = 0; k < REGCOUNT; k++) regs[k] = 8'h00;

        regs[0] = 8'h01; regs[1] = 8'd0; regs[2] = 8'd3; regs[3] = 8'd2;
        rst = 1'b1;
        step();
        step();
        check("reset_pwm_out", 32'(bus.pwm_out), 32'd0);
        check("reset_period_wrap", 32'(bus.period_wrap), 32'd0);
        check("reset_tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;

        check_period(0, 3, 2, 0, 2);
        regs[1] = 8'd1;
        check_period(0, 3, 2, 1, 2);

        regs[1] = 8'd0; regs[3] = 8'd1;
        check_period(0, 3, 1, 0, 1);
        for (int j = 1; j <= 8; j++) begin
            step();
            if (j == 2) regs[3] = 8'd3;
            check("late_duty_pwm", 32'(bus.pwm_out[0]), 32'((j <= 4) ? (j <= 1) : (j - 4 <= 3)));
            check("late_duty_wrap", 32'(bus.period_wrap[0]), 32'(j == 4 || j == 8));
        end

        regs[3] = 8'd0;
        check_period(0, 3, 0, 0, 2);
        regs[3] = 8'd5;
        check_period(0, 3, 5, 0, 2);
        regs[2] = 8'd0; regs[3] = 8'd1;
        check_period(0, 0, 1, 0, 6);

        regs[2] = 8'd2; regs[3] = 8'd1; regs[16] = 8'd5; regs[17] = 8'd4; regs[0] = 8'h81;
        found = 1'b0;
        for (int n2 = 0; n2 < 50 && !found; n2++) begin
            step();
            found = bus.pwm_out[7];
        end
        check("ch7_goes_high", 32'(found), 32'd1);
        regs[0] = 8'h01;
        step();
        check("disable_pwm7", 32'(bus.pwm_out[7]), 32'd0);
        check("disable_wrap7", 32'(bus.period_wrap[7]), 32'd0);
        step(); step(); step();
        regs[0] = 8'h81;
        step();
        check("reenable_pwm7_high", 32'(bus.pwm_out[7]), 32'd1);
        step();
        check("reenable_pwm7_hold", 32'(bus.pwm_out[7]), 32'd1);
        check_period(0, 2, 1, 0, 2);

        regs[1] = 8'd200;
        for (int j = 0; j < 50; j++) step();
        rst = 1'b1;
        step();
        check("midrun_reset_pwm", 32'(bus.pwm_out), 32'd0);
        check("midrun_reset_wrap", 32'(bus.period_wrap), 32'd0);
        check("midrun_reset_tick", 32'(bus.tick), 32'd0);
        rst = 1'b0;
        n = 0;
        found = 1'b0;
        for (int j = 0; j < 300 && !found; j++) begin
            step();
            n++;
            found = bus.tick;
        end
        check("first_tick_latency", 32'(n), 32'd201);

        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, REGCOUNT - 1);
                if (n == 1)      regs[n] = 8'($urandom_range(0, 3));
                else if (n == 0) regs[n] = 8'($urandom_range(0, 255));
                else             regs[n] = 8'($urandom_range(0, 12));
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
